// File: rtl/router_port_tx.sv
// Serial packet transmitter for one router input port: 4 address bits, pad, payload LSB first.
// Define ROUTER_TX_CNT_EN to add the tx_count port (packets completed, wraps at 255).
module router_port_tx #(
   parameter int PAD_CYCLES = 10,
   parameter int DATA_W     = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_da,
   input  logic [DATA_W-1:0] req_data,
   output logic              frame_n,
   output logic              valid_n,
   output logic              di,
   output logic              busy
`ifdef ROUTER_TX_CNT_EN
   ,
   output logic [7:0]        tx_count
`endif
);

   localparam int         SW        = DATA_W + 4;
   localparam logic [5:0] DATA_LAST = 6'(DATA_W - 1);
   localparam logic [7:0] PAD_LAST  = 8'(PAD_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, ADDR, PAD, DATA, GAP} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] sr_q, sr_d;
   logic [5:0]    cnt_q, cnt_d;
   logic [7:0]    pad_q, pad_d;
   logic          frame_n_q, frame_n_d;
   logic          valid_n_q, valid_n_d;
   logic          di_q, di_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (req_valid) state_d = ADDR;
         ADDR: if (cnt_q == 6'd3) state_d = (PAD_CYCLES == 0) ? DATA : PAD;
         PAD:  if (pad_q == PAD_LAST) state_d = DATA;
         DATA: if (cnt_q == DATA_LAST) state_d = GAP;
         GAP:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Everything below computes the value the line shows in the *next* cycle;
   // sr_q[0] is always the next bit to go out.
   always_comb begin
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      pad_d     = pad_q;
      frame_n_d = 1'b1;
      valid_n_d = 1'b1;
      di_d      = 1'b0;
      case (state_q)
         IDLE: if (req_valid) begin
            sr_d      = {req_data, req_da} >> 1;
            cnt_d     = 6'd0;
            frame_n_d = 1'b0;
            di_d      = req_da[0];
         end
         ADDR: begin
            frame_n_d = 1'b0;
            cnt_d     = cnt_q + 6'd1;
            if (cnt_q == 6'd3) begin
               cnt_d = 6'd0;
               pad_d = 8'd0;
               if (PAD_CYCLES == 0) begin
                  valid_n_d = 1'b0;
                  di_d      = sr_q[0];
                  sr_d      = sr_q >> 1;
               end else begin
                  di_d = 1'b1;
               end
            end else begin
               di_d = sr_q[0];
               sr_d = sr_q >> 1;
            end
         end
         PAD: begin
            frame_n_d = 1'b0;
            if (pad_q == PAD_LAST) begin
               valid_n_d = 1'b0;
               di_d      = sr_q[0];
               sr_d      = sr_q >> 1;
               cnt_d     = 6'd0;
            end else begin
               pad_d = pad_q + 8'd1;
               di_d  = 1'b1;
            end
         end
         DATA: if (cnt_q != DATA_LAST) begin
            // frame_n rises with the final payload bit to mark end of packet
            frame_n_d = (cnt_q == DATA_LAST - 6'd1);
            valid_n_d = 1'b0;
            di_d      = sr_q[0];
            sr_d      = sr_q >> 1;
            cnt_d     = cnt_q + 6'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sr_q      <= '0;
         cnt_q     <= '0;
         pad_q     <= '0;
         frame_n_q <= 1'b1;
         valid_n_q <= 1'b1;
         di_q      <= 1'b0;
      end else begin
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         pad_q     <= pad_d;
         frame_n_q <= frame_n_d;
         valid_n_q <= valid_n_d;
         di_q      <= di_d;
      end
   end

   assign frame_n   = frame_n_q;
   assign valid_n   = valid_n_q;
   assign di        = di_q;
   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);

`ifdef ROUTER_TX_CNT_EN
   logic [7:0] tx_count_q, tx_count_d;

   always_comb begin
      tx_count_d = tx_count_q;
      if (state_q == DATA && state_d == GAP) tx_count_d = tx_count_q + 8'd1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) tx_count_q <= 8'd0;
      else       tx_count_q <= tx_count_d;
   end

   assign tx_count = tx_count_q;
`endif

endmodule

// File: tb/tb_router_port_tx.sv
// Directed bench for router_port_tx: default-pad instance plus a PAD_CYCLES=0 instance.
// With ROUTER_TX_CNT_EN defined the packet counter and its wrap are checked too.
module tb_router_port_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        rv0, rdy0, fn0, vn0, di0, busy0;
   logic [3:0]  da0;
   logic [31:0] dat0;
   logic        rv1, rdy1, fn1, vn1, di1, busy1;
   logic [3:0]  da1;
   logic [31:0] dat1;
`ifdef ROUTER_TX_CNT_EN
   logic [7:0]  cnt0, cnt1;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int acc_cnt  = 0;
   int last_acc = 0;
   int prev_acc = 0;

   always #5 clk = ~clk;

   router_port_tx dut0 (
      .clock(clk), .reset(rst), .req_valid(rv0), .req_ready(rdy0), .req_da(da0),
      .req_data(dat0), .frame_n(fn0), .valid_n(vn0), .di(di0), .busy(busy0)
`ifdef ROUTER_TX_CNT_EN
      , .tx_count(cnt0)
`endif
   );

   router_port_tx #(.PAD_CYCLES(0)) dut1 (
      .clock(clk), .reset(rst), .req_valid(rv1), .req_ready(rdy1), .req_da(da1),
      .req_data(dat1), .frame_n(fn1), .valid_n(vn1), .di(di1), .busy(busy1)
`ifdef ROUTER_TX_CNT_EN
      , .tx_count(cnt1)
`endif
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && rv0 && rdy0) begin
         acc_cnt  <= acc_cnt + 1;
         prev_acc <= last_acc;
         last_acc <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic line0(input string tag, input logic f, input logic v, input logic d);
      chk(tag, {29'd0, fn0, vn0, di0}, {29'd0, f, v, d});
   endtask

   task automatic line1(input string tag, input logic f, input logic v, input logic d);
      chk(tag, {29'd0, fn1, vn1, di1}, {29'd0, f, v, d});
   endtask

   task automatic tick(input bit tog);
      if (tog) begin
         da0  = 4'($urandom);
         dat0 = $urandom;
      end
      @(negedge clk);
   endtask

   // Entered at the negedge right after the accept edge; leaves at the negedge of the idle cycle.
   task automatic expect_pkt0(input string tag, input logic [3:0] da, input logic [31:0] data,
                              input bit tog, output logic [31:0] rx);
      rx = '0;
      chk({tag, "_rdy_low"}, {31'd0, rdy0}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy0}, 32'd1);
      for (int i = 0; i < 4; i++) begin line0({tag, "_addr"}, 1'b0, 1'b1, da[i]); tick(tog); end
      for (int i = 0; i < 10; i++) begin line0({tag, "_pad"}, 1'b0, 1'b1, 1'b1); tick(tog); end
      for (int i = 0; i < 32; i++) begin
         line0({tag, "_data"}, (i == 31), 1'b0, data[i]);
         rx[i] = di0;
         tick(tog);
      end
      line0({tag, "_gap"}, 1'b1, 1'b1, 1'b0);
      chk({tag, "_gap_rdy"}, {31'd0, rdy0}, 32'd0);
      tick(tog);
      line0({tag, "_idle"}, 1'b1, 1'b1, 1'b0);
      chk({tag, "_idle_rdy"}, {31'd0, rdy0}, 32'd1);
      chk({tag, "_idle_busy"}, {31'd0, busy0}, 32'd0);
   endtask

   initial begin
      logic [31:0] rx;
      int span;
      rst = 1'b1;
      rv0 = 1'b0; da0 = '0; dat0 = '0;
      rv1 = 1'b0; da1 = '0; dat1 = '0;
      repeat (2) @(negedge clk);
      line0("reset_line", 1'b1, 1'b1, 1'b0);
      chk("reset_rdy", {31'd0, rdy0}, 32'd1);
      chk("reset_busy", {31'd0, busy0}, 32'd0);
`ifdef ROUTER_TX_CNT_EN
      chk("reset_cnt", {24'd0, cnt0}, 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // 1: basic packet
      da0 = 4'd7; dat0 = 32'hDEAD_BEEF; rv0 = 1'b1;
      @(negedge clk);
      rv0 = 1'b0;
      expect_pkt0("t1", 4'd7, 32'hDEAD_BEEF, 1'b0, rx);
      chk("t1_payload", rx, 32'hDEAD_BEEF);

      // 2: back-to-back with req_valid held
      da0 = 4'd3; dat0 = 32'hA5A5_0F0F; rv0 = 1'b1;
      @(negedge clk);
      da0 = 4'd5; dat0 = 32'h1234_5678;
      expect_pkt0("t2a", 4'd3, 32'hA5A5_0F0F, 1'b0, rx);
      chk("t2a_payload", rx, 32'hA5A5_0F0F);
      @(negedge clk);
      rv0 = 1'b0;
      expect_pkt0("t2b", 4'd5, 32'h1234_5678, 1'b0, rx);
      chk("t2b_payload", rx, 32'h1234_5678);
      chk("t2_spacing", 32'(last_acc - prev_acc), 32'd48);

      // 3: reset during data bit 10
      da0 = 4'd9; dat0 = 32'h0000_0400; rv0 = 1'b1;
      @(negedge clk);
      rv0 = 1'b0;
      repeat (24) @(negedge clk);
      line0("t3_bit10", 1'b0, 1'b0, 1'b1);
`ifdef ROUTER_TX_CNT_EN
      chk("t3_cnt_before", {24'd0, cnt0}, 32'd3);
`endif
      rst = 1'b1;
      #1;
      line0("t3_abort", 1'b1, 1'b1, 1'b0);
      chk("t3_abort_rdy", {31'd0, rdy0}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
`ifdef ROUTER_TX_CNT_EN
      chk("t3_cnt_abort", {24'd0, cnt0}, 32'd0);
`endif
      da0 = 4'hC; dat0 = 32'h0F1E_2D3C; rv0 = 1'b1;
      @(negedge clk);
      rv0 = 1'b0;
      expect_pkt0("t3n", 4'hC, 32'h0F1E_2D3C, 1'b0, rx);
      chk("t3n_payload", rx, 32'h0F1E_2D3C);
`ifdef ROUTER_TX_CNT_EN
      chk("t3_cnt_after", {24'd0, cnt0}, 32'd1);
`endif

      // 5: inputs churn after accept
      da0 = 4'hA; dat0 = 32'h8000_0001; rv0 = 1'b1;
      @(negedge clk);
      rv0 = 1'b0;
      expect_pkt0("t5", 4'hA, 32'h8000_0001, 1'b1, rx);
      chk("t5_payload", rx, 32'h8000_0001);

      // 4: zero pad on second instance
      da1 = 4'd0; dat1 = 32'hFFFF_FFFF; rv1 = 1'b1;
      @(negedge clk);
      rv1 = 1'b0;
      span = 0;
      for (int c = 0; c < 40; c++) begin
         if (c < 4)       line1("t4_addr", 1'b0, 1'b1, 1'b0);
         else if (c < 36) line1("t4_data", (c == 35), 1'b0, 1'b1);
         else             line1("t4_idle", 1'b1, 1'b1, 1'b0);
         if (!fn1) span++;
         @(negedge clk);
      end
      chk("t4_frame_span", 32'(span), 32'd35);

`ifdef ROUTER_TX_CNT_EN
      // 6: counter wrap over 257 packets
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      begin
         int base;
         base = acc_cnt;
         da0 = 4'd1; dat0 = 32'h5555_AAAA; rv0 = 1'b1;
         for (int c = 0; c < 20000 && (acc_cnt - base) < 257; c++) @(negedge clk);
         rv0 = 1'b0;
         chk("t6_accepts", 32'(acc_cnt - base), 32'd257);
      end
      repeat (60) @(negedge clk);
      chk("t6_cnt_wrap", {24'd0, cnt0}, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
